// File: rtl/cuenta1_arb_pkg.sv
// Shared state encodings, default widths and the round-robin pick
// used by the two-requester ones-counter.
package cuenta1_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int N_DEF  = 8;
    localparam int CW_DEF = $clog2(N_DEF + 1);

    // Returns the index of the requester that wins this cycle.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
        if (req0 && req1) begin
            return ptr;
        end
        return req1;
    endfunction

endpackage

// File: rtl/uc_cuenta1_arb.sv
// Control unit: round-robin arbiter plus the IDLE/SHIFT/DONE sequencer.
// Grants and completions are registered; datapath strobes are decoded from state.
module uc_cuenta1_arb
    import cuenta1_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic q_zero_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic fin0_o,
    output logic fin1_o,
    output logic busy_o,
    output logic owner_o,
    output logic load_o,
    output logic shift_o,
    output logic done_o
);

    state_e state_q;
    logic   owner_q;
    logic   ptr_q;
    logic   gnt_q;
    logic   fin0_q;
    logic   fin1_q;
    logic   any_req;
    logic   winner;

    assign any_req = req0_i | req1_i;
    assign winner  = rr_pick(req0_i, req1_i, ptr_q);

    // The grant is decided in IDLE (or in DONE for back-to-back service) and
    // shows up the following cycle, when the FSM is still IDLE; the operand is
    // captured at the end of that grant cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            fin0_q  <= 1'b0;
            fin1_q  <= 1'b0;
        end else begin
            gnt_q  <= 1'b0;
            fin0_q <= 1'b0;
            fin1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_q) begin
                        state_q <= ST_SHIFT;
                    end else if (any_req) begin
                        gnt_q   <= 1'b1;
                        owner_q <= winner;
                        ptr_q   <= ~winner;
                    end
                end
                ST_SHIFT: begin
                    if (q_zero_i) begin
                        state_q <= ST_DONE;
                        fin0_q  <= ~owner_q;
                        fin1_q  <= owner_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (any_req) begin
                        gnt_q   <= 1'b1;
                        owner_q <= winner;
                        ptr_q   <= ~winner;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0_o  = gnt_q & ~owner_q;
    assign gnt1_o  = gnt_q & owner_q;
    assign fin0_o  = fin0_q;
    assign fin1_o  = fin1_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;
    assign load_o  = (state_q == ST_IDLE) & gnt_q;
    assign shift_o = (state_q == ST_SHIFT) & ~q_zero_i;
    assign done_o  = (state_q == ST_SHIFT) & q_zero_i;

endmodule

// File: rtl/cuenta1_arb.sv
// Two-requester ones-counter: shift-and-add datapath with early termination,
// sequenced by uc_cuenta1_arb.
module cuenta1_arb
    import cuenta1_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [N-1:0]  valor0,
    input  logic [N-1:0]  valor1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic [CW-1:0] cuenta,
    output logic          fin0,
    output logic          fin1
);

    logic [N-1:0]  q_q;
    logic [N-1:0]  q_d;
    logic [CW-1:0] a_q;
    logic [CW-1:0] a_d;
    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] cuenta_d;
    logic          load;
    logic          shift;
    logic          done_enter;
    logic          owner;
    logic          q_zero;

    assign q_zero = (q_q == '0);

    uc_cuenta1_arb u_uc (
        .clk      (clk),
        .reset    (reset),
        .req0_i   (req0),
        .req1_i   (req1),
        .q_zero_i (q_zero),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .fin0_o   (fin0),
        .fin1_o   (fin1),
        .busy_o   (busy),
        .owner_o  (owner),
        .load_o   (load),
        .shift_o  (shift),
        .done_o   (done_enter)
    );

    // cuenta is a separate register so partial sums in A never reach the port.
    always_comb begin
        q_d      = q_q;
        a_d      = a_q;
        cuenta_d = cuenta_q;
        if (load) begin
            q_d = owner ? valor1 : valor0;
            a_d = '0;
        end else if (shift) begin
            a_d = a_q + {{(CW-1){1'b0}}, q_q[0]};
            q_d = q_q >> 1;
        end
        if (done_enter) begin
            cuenta_d = a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q      <= '0;
            a_q      <= '0;
            cuenta_q <= '0;
        end else begin
            q_q      <= q_d;
            a_q      <= a_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule
